// File: rtl/vip_pkg.sv
// Shared types and defaults for the 3x3 window line-buffer sequencer.
package vip_pkg;

  localparam int CNT_W_DEF     = 11;
  localparam int IMG_W_MAX_DEF = 1024;
  localparam int IMG_H_MAX_DEF = 1024;
  localparam int PIPE_DLY_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    IN_LINE   = 2'd2
  } state_e;

endpackage

// File: rtl/vip_sync_delay.sv
// Fixed-depth shift register that re-times a bundle of sync/index bits.
module vip_sync_delay #(
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [DEPTH-1:0][W-1:0] pipe_q, pipe_d;

  // Next pipe contents: new sample enters stage 0, every other stage shifts by one.
  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = din;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end

  // Pipe register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) pipe_q <= '0;
    else        pipe_q <= pipe_d;
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/vip_window_ctrl.sv
// Sequencer for the 2-line shift-RAM buffer in front of the 3x3 filter.
// Tracks frame/line/pixel position, gates the line-buffer enables and re-times
// the syncs and pixel index to the tap latency.
// Optional: LINE_LEN_CHECK_EN adds a sticky line_len_err output that flags any
// line whose pixel count differs from the first line of the frame.
module vip_window_ctrl
  import vip_pkg::*;
#(
  parameter int IMG_W_MAX = IMG_W_MAX_DEF,
  parameter int IMG_H_MAX = IMG_H_MAX_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int PIPE_DLY  = PIPE_DLY_DEF
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  output logic             lb_href,
  output logic             lb_clken,
  output logic             post_frame_vsync,
  output logic             post_frame_href,
  output logic             post_frame_clken,
  output logic [CNT_W-1:0] col_idx,
  output logic [CNT_W-1:0] row_idx,
  output logic             win_valid,
  output logic             ovf_err
`ifdef LINE_LEN_CHECK_EN
  , output logic           line_len_err
`endif
);

  localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(IMG_W_MAX - 1);
  localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(IMG_H_MAX - 1);
  localparam int               DLY_W   = 3 + 2 * CNT_W;

  state_e                 state_q, state_d;
  logic                   vsync_q, vsync_d;
  logic [CNT_W-1:0]       col_q, col_d, row_q, row_d;
  logic                   ovf_q, ovf_d;
  logic [2*CNT_W-1:0]     idx_q, idx_d;
  logic                   vs_rise, frame_act, line_end;
  logic [DLY_W-1:0]       dly_in, dly_out;

  assign vs_rise  = per_frame_vsync & ~vsync_q;
  // A frame start in the same cycle as href already owns the pixel, so treat it as active.
  assign line_end = (state_q == IN_LINE) & ~per_frame_href & ~vs_rise;
  assign vsync_d  = per_frame_vsync;

  // State, counter and sticky-flag registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vsync_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      vsync_q <= vsync_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: frame start from anywhere, then alternate between blanking and line.
  always_comb begin
    state_d = state_q;
    if (vs_rise) state_d = WAIT_LINE;
    else begin
      case (state_q)
        IDLE:      state_d = IDLE;
        WAIT_LINE: if (per_frame_href)  state_d = IN_LINE;
        IN_LINE:   if (!per_frame_href) state_d = WAIT_LINE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Line-buffer enables: pass-through once a frame has started, no added latency.
  always_comb begin
    frame_act = (state_q != IDLE) | vs_rise;
    lb_href   = per_frame_href & frame_act;
    lb_clken  = per_frame_clken & lb_href;
  end

  // Position counters with saturation; index of a pixel is the count before increment.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    ovf_d = ovf_q;
    idx_d = idx_q;
    if (vs_rise) begin
      row_d = '0;
      col_d = lb_clken ? CNT_W'(1) : '0;
      ovf_d = 1'b0;
    end else begin
      if (!per_frame_href) col_d = '0;
      else if (lb_clken) begin
        if (col_q == COL_MAX) ovf_d = 1'b1;
        else                  col_d = col_q + CNT_W'(1);
      end
      if (line_end) begin
        if (row_q == ROW_MAX) ovf_d = 1'b1;
        else                  row_d = row_q + CNT_W'(1);
      end
    end
    if (lb_clken) idx_d = vs_rise ? '0 : {row_q, col_q};
  end

  // Index fed into the delay holds its last value between pixels.
  assign dly_in = {per_frame_vsync & frame_act, lb_href, lb_clken, idx_d};

  vip_sync_delay #(.W(DLY_W), .DEPTH(PIPE_DLY)) u_sync_dly (
    .clock (clock),
    .rst_n (rst_n),
    .din   (dly_in),
    .dout  (dly_out)
  );

  assign {post_frame_vsync, post_frame_href, post_frame_clken, row_idx, col_idx} = dly_out;
  assign win_valid = post_frame_clken & (row_idx >= CNT_W'(2)) & (col_idx >= CNT_W'(2));
  assign ovf_err   = ovf_q;

`ifdef LINE_LEN_CHECK_EN
  logic [CNT_W-1:0] ref_len_q, ref_len_d;
  logic             ref_vld_q, ref_vld_d;
  logic             len_err_q, len_err_d;

  // First completed line of a frame sets the reference; later lines compare to it.
  always_comb begin
    ref_len_d = ref_len_q;
    ref_vld_d = ref_vld_q;
    len_err_d = len_err_q;
    if (vs_rise) begin
      ref_vld_d = 1'b0;
      len_err_d = 1'b0;
    end else if (line_end) begin
      if (!ref_vld_q) begin
        ref_len_d = col_q;
        ref_vld_d = 1'b1;
      end else if (col_q != ref_len_q) len_err_d = 1'b1;
    end
  end

  // Line-length reference registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ref_len_q <= '0;
      ref_vld_q <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      ref_len_q <= ref_len_d;
      ref_vld_q <= ref_vld_d;
      len_err_q <= len_err_d;
    end
  end

  assign line_len_err = len_err_q;
`endif

endmodule

// File: tb/tb_vip_window_ctrl.sv
// Directed bench for vip_window_ctrl (IMG_W_MAX=16, IMG_H_MAX=8, PIPE_DLY=2).
module tb_vip_window_ctrl;

  localparam int CNT_W = 11;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic vs = 1'b0, hr = 1'b0, ce = 1'b0;
  logic lb_href, lb_clken, p_vs, p_hr, p_ce, win_valid, ovf_err;
  logic [CNT_W-1:0] col_idx, row_idx;
`ifdef LINE_LEN_CHECK_EN
  logic line_len_err;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int lb_cnt, pv_cnt, win_cnt, win_bad;
  int lb_cyc[$], pc_row[$], pc_col[$], win_row[$], win_col[$], win_cyc[$];

  vip_window_ctrl #(.IMG_W_MAX(16), .IMG_H_MAX(8), .CNT_W(CNT_W), .PIPE_DLY(2)) dut (
    .clock            (clock),
    .rst_n            (rst_n),
    .per_frame_vsync  (vs),
    .per_frame_href   (hr),
    .per_frame_clken  (ce),
    .lb_href          (lb_href),
    .lb_clken         (lb_clken),
    .post_frame_vsync (p_vs),
    .post_frame_href  (p_hr),
    .post_frame_clken (p_ce),
    .col_idx          (col_idx),
    .row_idx          (row_idx),
    .win_valid        (win_valid),
    .ovf_err          (ovf_err)
`ifdef LINE_LEN_CHECK_EN
    , .line_len_err   (line_len_err)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Event logger, sampled mid-cycle.
  always @(negedge clock) begin
    if (rst_n) begin
      if (lb_clken) begin lb_cnt++; lb_cyc.push_back(cyc); end
      if (p_vs) pv_cnt++;
      if (p_ce) begin pc_row.push_back(int'(row_idx)); pc_col.push_back(int'(col_idx)); end
      if (win_valid) begin
        win_cnt++;
        win_row.push_back(int'(row_idx));
        win_col.push_back(int'(col_idx));
        win_cyc.push_back(cyc);
        if (!p_ce) win_bad++;
      end
    end
  end

  task automatic clear_logs();
    lb_cnt = 0; pv_cnt = 0; win_cnt = 0; win_bad = 0;
    lb_cyc.delete(); pc_row.delete(); pc_col.delete();
    win_row.delete(); win_col.delete(); win_cyc.delete();
  endtask

  task automatic drive(input logic v, input logic h, input logic c);
    @(posedge clock); #1;
    vs = v; hr = h; ce = c;
  endtask

  task automatic vs_pulse();
    drive(1, 0, 0); drive(1, 0, 0); drive(0, 0, 0); drive(0, 0, 0);
  endtask

  // One line of w pixels; clken stays high on the href-fall cycle (must not count).
  task automatic send_line(input int w, input bit toggle);
    for (int i = 0; i < w; i++) begin
      drive(0, 1, 1);
      if (toggle) drive(0, 1, 0);
    end
    drive(0, 0, 1); drive(0, 0, 0); drive(0, 0, 0);
  endtask

  task automatic flush();
    repeat (4) drive(0, 0, 0);
  endtask

  task automatic test_reset();
    logic [2*CNT_W+7:0] outs;
    repeat (3) drive(0, 0, 0);
    @(negedge clock);
    outs = {lb_href, lb_clken, p_vs, p_hr, p_ce, col_idx, row_idx, win_valid, ovf_err};
    n_cmp++; if (outs !== '0) begin n_err++; $display("FAIL reset_init: outs=%h exp 0", outs); end
    rst_n = 1'b1;
    vs_pulse();
    repeat (3) drive(0, 1, 1);
    @(negedge clock);
    n_cmp++; if (lb_clken !== 1'b1) begin n_err++; $display("FAIL pre_reset_clken: got %b exp 1", lb_clken); end
    @(posedge clock); #1; rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      outs = {lb_href, lb_clken, p_vs, p_hr, p_ce, col_idx, row_idx, win_valid, ovf_err};
      n_cmp++; if (outs !== '0) begin n_err++; $display("FAIL reset_mid_frame[%0d]: outs=%h exp 0", i, outs); end
      if (i < 2) @(posedge clock);
    end
    @(posedge clock); #1; rst_n = 1'b1;
    clear_logs();
    repeat (5) drive(0, 1, 1);
    drive(0, 0, 0); flush();
    n_cmp++; if (lb_cnt !== 0) begin n_err++; $display("FAIL post_reset_lb_clken: got %0d exp 0", lb_cnt); end
    n_cmp++; if (pc_row.size() !== 0) begin n_err++; $display("FAIL post_reset_post_clken: got %0d exp 0", pc_row.size()); end
  endtask

  task automatic test_frame();
    clear_logs();
    vs_pulse();
    repeat (4) send_line(8, 0);
    flush();
    n_cmp++; if (pv_cnt !== 2) begin n_err++; $display("FAIL frame_post_vsync: got %0d exp 2", pv_cnt); end
    n_cmp++; if (lb_cnt !== 32) begin n_err++; $display("FAIL frame_lb_clken: got %0d exp 32", lb_cnt); end
    n_cmp++; if (pc_row.size() !== 32) begin n_err++; $display("FAIL frame_post_clken: got %0d exp 32", pc_row.size()); end
    for (int k = 0; k < 32 && k < pc_row.size(); k++) begin
      n_cmp++;
      if (pc_row[k] !== k / 8 || pc_col[k] !== k % 8) begin
        n_err++; $display("FAIL frame_idx[%0d]: got r%0d c%0d exp r%0d c%0d", k, pc_row[k], pc_col[k], k / 8, k % 8);
      end
    end
    n_cmp++; if (win_cnt !== 12) begin n_err++; $display("FAIL frame_win_cnt: got %0d exp 12", win_cnt); end
    for (int k = 0; k < 12 && k < win_row.size(); k++) begin
      n_cmp++;
      if (win_row[k] !== 2 + k / 6 || win_col[k] !== 2 + k % 6) begin
        n_err++; $display("FAIL frame_win[%0d]: got r%0d c%0d exp r%0d c%0d", k, win_row[k], win_col[k], 2 + k / 6, 2 + k % 6);
      end
    end
    if (win_cyc.size() > 0 && lb_cyc.size() > 18) begin
      n_cmp++;
      if (win_cyc[0] - lb_cyc[18] !== 2) begin
        n_err++; $display("FAIL frame_win_latency: got %0d exp 2", win_cyc[0] - lb_cyc[18]);
      end
    end else begin
      n_cmp++; n_err++; $display("FAIL frame_win_latency: missing events");
    end
    n_cmp++; if (win_bad !== 0) begin n_err++; $display("FAIL frame_win_without_clken: got %0d exp 0", win_bad); end
  endtask

  task automatic test_toggle();
    clear_logs();
    vs_pulse();
    repeat (4) send_line(8, 1);
    flush();
    n_cmp++; if (lb_cnt !== 32) begin n_err++; $display("FAIL toggle_lb_clken: got %0d exp 32", lb_cnt); end
    n_cmp++; if (win_cnt !== 12) begin n_err++; $display("FAIL toggle_win_cnt: got %0d exp 12", win_cnt); end
    for (int k = 0; k < 32 && k < pc_row.size(); k++) begin
      n_cmp++;
      if (pc_row[k] !== k / 8 || pc_col[k] !== k % 8) begin
        n_err++; $display("FAIL toggle_idx[%0d]: got r%0d c%0d exp r%0d c%0d", k, pc_row[k], pc_col[k], k / 8, k % 8);
      end
    end
    for (int k = 0; k < 12 && k < win_row.size(); k++) begin
      n_cmp++;
      if (win_row[k] !== 2 + k / 6 || win_col[k] !== 2 + k % 6) begin
        n_err++; $display("FAIL toggle_win[%0d]: got r%0d c%0d exp r%0d c%0d", k, win_row[k], win_col[k], 2 + k / 6, 2 + k % 6);
      end
    end
  endtask

  task automatic test_col_sat();
    int n15;
    clear_logs();
    vs_pulse();
    repeat (15) drive(0, 1, 1);
    @(negedge clock);
    n_cmp++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL col_sat_early_ovf: got %b exp 0", ovf_err); end
    repeat (5) drive(0, 1, 1);
    drive(0, 0, 1); flush();
    @(negedge clock);
    n_cmp++; if (ovf_err !== 1'b1) begin n_err++; $display("FAIL col_sat_ovf: got %b exp 1", ovf_err); end
    n_cmp++; if (lb_cnt !== 20) begin n_err++; $display("FAIL col_sat_lb_clken: got %0d exp 20", lb_cnt); end
    n15 = 0;
    foreach (pc_col[k]) if (pc_col[k] == 15) n15++;
    n_cmp++; if (n15 !== 5) begin n_err++; $display("FAIL col_sat_hold15: got %0d exp 5", n15); end
    n_cmp++; if (col_idx !== 11'd15) begin n_err++; $display("FAIL col_sat_last_idx: got %0d exp 15", col_idx); end
    vs_pulse();
    @(negedge clock);
    n_cmp++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL col_sat_clear: got %b exp 0", ovf_err); end
  endtask

  task automatic test_row_sat();
    clear_logs();
    vs_pulse();
    repeat (7) send_line(1, 0);
    @(negedge clock);
    n_cmp++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL row_sat_early_ovf: got %b exp 0", ovf_err); end
    send_line(1, 0);
    @(negedge clock);
    n_cmp++; if (ovf_err !== 1'b1) begin n_err++; $display("FAIL row_sat_ovf: got %b exp 1", ovf_err); end
    send_line(1, 0); flush();
    n_cmp++; if (pc_row.size() !== 9) begin n_err++; $display("FAIL row_sat_count: got %0d exp 9", pc_row.size()); end
    if (pc_row.size() == 9) begin
      n_cmp++; if (pc_row[8] !== 7) begin n_err++; $display("FAIL row_sat_hold7: got %0d exp 7", pc_row[8]); end
    end
    n_cmp++; if (ovf_err !== 1'b1) begin n_err++; $display("FAIL row_sat_sticky: got %b exp 1", ovf_err); end
  endtask

  task automatic test_vs_abort();
    clear_logs();
    vs_pulse();
    send_line(8, 0);
    repeat (3) drive(0, 1, 1);
    drive(1, 0, 0); drive(1, 0, 0); drive(0, 0, 0);
    flush();
    n_cmp++; if (win_cnt !== 0) begin n_err++; $display("FAIL abort_pre_win: got %0d exp 0", win_cnt); end
    n_cmp++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL abort_ovf_clear: got %b exp 0", ovf_err); end
    clear_logs();
    repeat (4) send_line(8, 0);
    flush();
    n_cmp++; if (pc_row.size() !== 32) begin n_err++; $display("FAIL abort_post_clken: got %0d exp 32", pc_row.size()); end
    if (pc_row.size() > 0) begin
      n_cmp++; if (pc_row[0] !== 0 || pc_col[0] !== 0) begin n_err++; $display("FAIL abort_first_idx: got r%0d c%0d exp r0 c0", pc_row[0], pc_col[0]); end
    end
    n_cmp++; if (win_cnt !== 12) begin n_err++; $display("FAIL abort_win_cnt: got %0d exp 12", win_cnt); end
    if (win_row.size() > 0) begin
      n_cmp++; if (win_row[0] !== 2 || win_col[0] !== 2) begin n_err++; $display("FAIL abort_first_win: got r%0d c%0d exp r2 c2", win_row[0], win_col[0]); end
    end
  endtask

  // Frame start and href in the same cycle, from a state with row count left at 4.
  task automatic test_back_to_back();
    clear_logs();
    drive(1, 1, 1);
    repeat (7) drive(0, 1, 1);
    drive(0, 0, 1); flush();
    n_cmp++; if (lb_cnt !== 8) begin n_err++; $display("FAIL same_cycle_lb_clken: got %0d exp 8", lb_cnt); end
    n_cmp++; if (pc_row.size() !== 8) begin n_err++; $display("FAIL same_cycle_post_clken: got %0d exp 8", pc_row.size()); end
    if (pc_row.size() == 8) begin
      n_cmp++; if (pc_row[0] !== 0 || pc_col[0] !== 0) begin n_err++; $display("FAIL same_cycle_first: got r%0d c%0d exp r0 c0", pc_row[0], pc_col[0]); end
      n_cmp++; if (pc_row[7] !== 0 || pc_col[7] !== 7) begin n_err++; $display("FAIL same_cycle_last: got r%0d c%0d exp r0 c7", pc_row[7], pc_col[7]); end
    end
  endtask

`ifdef LINE_LEN_CHECK_EN
  task automatic test_line_len();
    vs_pulse();
    send_line(8, 0); send_line(8, 0);
    @(negedge clock);
    n_cmp++; if (line_len_err !== 1'b0) begin n_err++; $display("FAIL len_equal: got %b exp 0", line_len_err); end
    send_line(7, 0);
    @(negedge clock);
    n_cmp++; if (line_len_err !== 1'b1) begin n_err++; $display("FAIL len_short: got %b exp 1", line_len_err); end
    send_line(8, 0);
    @(negedge clock);
    n_cmp++; if (line_len_err !== 1'b1) begin n_err++; $display("FAIL len_sticky: got %b exp 1", line_len_err); end
    vs_pulse();
    @(negedge clock);
    n_cmp++; if (line_len_err !== 1'b0) begin n_err++; $display("FAIL len_clear: got %b exp 0", line_len_err); end
  endtask
`endif

  initial begin
    clear_logs();
    test_reset();
    test_frame();
    test_toggle();
    test_col_sat();
    test_row_sat();
    test_vs_abort();
    test_back_to_back();
`ifdef LINE_LEN_CHECK_EN
    test_line_len();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
